// File: rtl/conv_enc_sched_pkg.sv
// conv_enc_sched_pkg: shared constants and FSM state type for the encoder frame scheduler.
package conv_enc_sched_pkg;
    localparam int FRAME_LEN_DEF         = 128;
    localparam int ENC_W                 = 384;
    localparam int MAX_CODE_RATE         = 3;
    localparam int MAX_CONSTRAINT_LENGTH = 7;
    localparam int POLY_W                = MAX_CODE_RATE * MAX_CONSTRAINT_LENGTH;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, OUT} state_t;
endpackage

// File: rtl/conv_enc_shreg.sv
// conv_enc_shreg: loadable MSB-first shift register with a saturating bit counter and last flag.
module conv_enc_shreg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         msb,
    output logic         last
);
    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  data;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            data  <= {data[W-2:0], 1'b0};
            count <= (count == CW'(W)) ? count : count + CW'(1);
        end
    end

    assign msb  = data[W-1];
    assign last = count == CW'(W - 1);
endmodule

// File: rtl/conv_enc_sched.sv
// conv_enc_sched: accepts a frame, clears and feeds an external convolutional encoder, returns its result.
// Define TIMEOUT_EN to bound the wait for encoder done to DONE_TIMEOUT cycles.
module conv_enc_sched
    import conv_enc_sched_pkg::*;
#(
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    input  logic [FRAME_LEN-1:0] i_req_data,
    input  logic                 i_req_rate,
    input  logic [POLY_W-1:0]    i_req_poly,
    output logic                 o_req_ready,
    output logic                 o_enc_rst,
    output logic                 o_en_ce,
    output logic                 o_tx_data,
    output logic [POLY_W-1:0]    o_gen_poly,
    output logic                 o_code_rate,
    input  logic [ENC_W-1:0]     i_encoder_data,
    input  logic                 i_encoder_done,
    output logic                 o_out_valid,
    output logic [ENC_W-1:0]     o_out_data,
    output logic                 o_out_error,
    input  logic                 i_out_ready
);
    state_t state, state_nx;
    logic   accept, last, msb, timeout;

    assign accept      = i_req_valid && state == IDLE;
    assign o_req_ready = state == IDLE;
    assign o_en_ce     = state == FEED;
    assign o_tx_data   = o_en_ce && msb;
    assign o_out_valid = state == OUT;

    conv_enc_shreg #(.W(FRAME_LEN)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (o_en_ce),
        .load_data (i_req_data),
        .msb       (msb),
        .last      (last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CLEAR : IDLE;
            CLEAR:   state_nx = FEED;
            FEED:    state_nx = last ? WAIT : FEED;
            WAIT:    state_nx = (i_encoder_done || timeout) ? OUT : WAIT;
            OUT:     state_nx = i_out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    // Encoder clear is registered from the next state so it is low exactly during CLEAR and in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            o_enc_rst   <= 1'b0;
            o_gen_poly  <= '0;
            o_code_rate <= 1'b0;
            o_out_data  <= '0;
        end else begin
            state     <= state_nx;
            o_enc_rst <= state_nx != CLEAR;
            if (accept) begin
                o_gen_poly  <= i_req_poly;
                o_code_rate <= i_req_rate;
            end
            if (state == WAIT && state_nx == OUT)
                o_out_data <= i_encoder_done ? i_encoder_data : '0;
        end
    end

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    assign timeout = wait_cnt == TW'(DONE_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            o_out_error <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
            if (state == WAIT && state_nx == OUT)
                o_out_error <= !i_encoder_done;
        end
    end
`else
    localparam int unused_done_timeout = DONE_TIMEOUT;

    assign timeout     = 1'b0;
    assign o_out_error = 1'b0;
`endif
endmodule
